// File: rtl/peripheral_mpram_pkg.sv
// rtl/peripheral_mpram_pkg.sv - shared state type and sizing helpers for the multiport RAM
package peripheral_mpram_pkg;

  localparam int MPRAM_MAX_PORTS = 4;

  typedef enum logic {
    MPRAM_CLEAR,
    MPRAM_READY
  } mpram_state_t;

  function automatic int mpram_bytes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int mpram_depth(input int mem_size, input int data_width);
    return mem_size / (data_width / 8);
  endfunction

endpackage

// File: rtl/peripheral_mpram_arbiter.sv
// rtl/peripheral_mpram_arbiter.sv - per-lane write arbitration across ports sharing an address
module peripheral_mpram_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_MSB  = 7,
  parameter int BYTES     = 2,
  parameter int DEPTH     = 128
) (
  input  logic                          enable,
  input  logic [NUM_PORTS*ADDR_MSB-1:0] addr,
  input  logic [NUM_PORTS-1:0]          cen,
  input  logic [NUM_PORTS*BYTES-1:0]    wen,
  output logic [NUM_PORTS-1:0]          in_range,
  output logic [NUM_PORTS*BYTES-1:0]    grant,
  output logic [NUM_PORTS-1:0]          collision
);

  logic [NUM_PORTS*BYTES-1:0] req;

  always_comb begin
    in_range = '0;
    req      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_range[p] = 32'(addr[p*ADDR_MSB +: ADDR_MSB]) < DEPTH;
      for (int b = 0; b < BYTES; b++) begin
        req[p*BYTES+b] = enable & ~cen[p] & ~wen[p*BYTES+b] & in_range[p];
      end
    end
  end

  // A lane is granted unless a lower-index port targets the same word and lane.
  always_comb begin
    grant     = '0;
    collision = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < BYTES; b++) begin
        grant[p*BYTES+b] = req[p*BYTES+b];
        for (int q = 0; q < p; q++) begin
          if (req[q*BYTES+b] &&
              (addr[q*ADDR_MSB +: ADDR_MSB] == addr[p*ADDR_MSB +: ADDR_MSB])) begin
            grant[p*BYTES+b] = 1'b0;
          end
        end
        if (req[p*BYTES+b] && !grant[p*BYTES+b]) begin
          collision[p] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/peripheral_mpram_multiport.sv
// rtl/peripheral_mpram_multiport.sv - N-port byte-writable RAM with power-up clear
// Define PERIPHERAL_MPRAM_OUTREG_EN to add a second output register stage (2-cycle reads).
module peripheral_mpram_multiport
  import peripheral_mpram_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_MSB   = 7,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 256
) (
  input  logic                              ram_clk,
  input  logic                              ram_rst_n,
  input  logic [NUM_PORTS*ADDR_MSB-1:0]     ram_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   ram_din,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   ram_dout,
  input  logic [NUM_PORTS-1:0]              ram_cen,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] ram_wen,
  output logic                              ram_ready,
  output logic [NUM_PORTS-1:0]              ram_collision
);

  localparam int BYTES = mpram_bytes(DATA_WIDTH);
  localparam int DEPTH = mpram_depth(MEM_SIZE, DATA_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  mpram_state_t                     state;
  logic [IDX_W-1:0]                 cnt;
  logic                             ready_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0]  dout_q;
  logic [NUM_PORTS-1:0]             coll_q;

  logic [NUM_PORTS-1:0]             in_range;
  logic [NUM_PORTS*BYTES-1:0]       grant;
  logic [NUM_PORTS-1:0]             coll;

  peripheral_mpram_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .ADDR_MSB  (ADDR_MSB),
    .BYTES     (BYTES),
    .DEPTH     (DEPTH)
  ) u_arbiter (
    .enable    (ready_q),
    .addr      (ram_addr),
    .cen       (ram_cen),
    .wen       (ram_wen),
    .in_range  (in_range),
    .grant     (grant),
    .collision (coll)
  );

  // Array has no reset; the clear sequencer is what makes its contents defined.
  always_ff @(posedge ram_clk) begin
    if (state == MPRAM_CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (grant[p*BYTES+b]) begin
            mem[ram_addr[p*ADDR_MSB +: IDX_W]][b*8 +: 8] <= ram_din[p*DATA_WIDTH+b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      state   <= MPRAM_CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        MPRAM_CLEAR: begin
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state   <= MPRAM_READY;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        MPRAM_READY: begin
          state   <= MPRAM_READY;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= MPRAM_CLEAR;
          cnt     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Read-first: the array read samples the value before this edge's writes land.
  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      dout_q <= '0;
      coll_q <= '0;
    end else begin
      coll_q <= coll;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (ready_q && !ram_cen[p]) begin
          dout_q[p*DATA_WIDTH +: DATA_WIDTH] <= in_range[p] ? mem[ram_addr[p*ADDR_MSB +: IDX_W]]
                                                            : '0;
        end
      end
    end
  end

  assign ram_ready = ready_q;

`ifdef PERIPHERAL_MPRAM_OUTREG_EN
  logic [NUM_PORTS*DATA_WIDTH-1:0] dout_q2;
  logic [NUM_PORTS-1:0]            coll_q2;

  always_ff @(posedge ram_clk or negedge ram_rst_n) begin
    if (!ram_rst_n) begin
      dout_q2 <= '0;
      coll_q2 <= '0;
    end else begin
      dout_q2 <= dout_q;
      coll_q2 <= coll_q;
    end
  end

  assign ram_dout      = dout_q2;
  assign ram_collision = coll_q2;
`else
  assign ram_dout      = dout_q;
  assign ram_collision = coll_q;
`endif

endmodule

// File: tb/tb_peripheral_mpram_multiport.sv
// tb/tb_peripheral_mpram_multiport.sv - directed self-checking bench for the multiport RAM
module tb_peripheral_mpram_multiport;

  localparam int NP = 2;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MS = 256;
`ifdef PERIPHERAL_MPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  din;
  logic [NP*DW-1:0]  dout;
  logic [NP-1:0]     cen;
  logic [NP*2-1:0]   wen;
  logic              ready;
  logic [NP-1:0]     collision;

  int total;
  int bad;
  int cyc;

  peripheral_mpram_multiport #(
    .NUM_PORTS  (NP),
    .ADDR_MSB   (AW),
    .DATA_WIDTH (DW),
    .MEM_SIZE   (MS)
  ) dut (
    .ram_clk       (clk),
    .ram_rst_n     (rst_n),
    .ram_addr      (addr),
    .ram_din       (din),
    .ram_dout      (dout),
    .ram_cen       (cen),
    .ram_wen       (wen),
    .ram_ready     (ready),
    .ram_collision (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle();
    cen = '1;
    wen = '1;
  endtask

  task automatic drive(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] w);
    addr[p*AW +: AW] = a;
    din[p*DW +: DW]  = d;
    wen[p*2 +: 2]    = w;
    cen[p]           = 1'b0;
  endtask

  task automatic read_word(input int p, input logic [AW-1:0] a, output logic [DW-1:0] d);
    idle();
    drive(p, a, '0, 2'b11);
    @(negedge clk);
    idle();
    repeat (LAT - 1) @(negedge clk);
    d = dout[p*DW +: DW];
  endtask

  task automatic wait_ready(input string name);
    int c0;
    c0 = cyc;
    while (!ready && (cyc - c0) < 400) @(negedge clk);
    total++;
    if ((cyc - c0) !== 128) begin
      bad++;
      $display("FAIL %s: clear took %0d cycles, required 128", name, cyc - c0);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    int nz;
    idle();
    addr = '0;
    din  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (dout !== '0) begin bad++; $display("FAIL reset_dout: got %h want 0", dout); end
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    total++;
    if (collision !== '0) begin bad++; $display("FAIL reset_coll: got %b want 0", collision); end
    rst_n = 1'b1;
    fork
      wait_ready("clear_len");
      begin
        repeat (50) @(negedge clk);
        drive(0, 8'd10, 16'hFFFF, 2'b00);
        drive(1, 8'd10, 16'h0F0F, 2'b00);
        @(negedge clk);
        idle();
        repeat (LAT - 1) @(negedge clk);
        total++;
        if (collision !== 2'b00) begin
          bad++; $display("FAIL clear_gate_coll: got %b want 00", collision);
        end
        read_word(0, 8'd10, d);
        total++;
        if (d !== 16'h0000) begin bad++; $display("FAIL clear_gate_dout: got %h want 0000", d); end
      end
    join
    nz = 0;
    for (int i = 0; i < 128; i++) begin
      read_word(i % 2, AW'(i), d);
      if (d !== 16'h0000) nz++;
    end
    total++;
    if (nz !== 0) begin bad++; $display("FAIL clear_all_zero: %0d nonzero words, want 0", nz); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    idle();
    drive(0, 8'd5, 16'hA5C3, 2'b00);
    @(negedge clk);
    read_word(1, 8'd5, d);
    total++;
    if (d !== 16'hA5C3) begin bad++; $display("FAIL write_read: got %h want a5c3", d); end
    addr[AW +: AW] = 8'd7;
    repeat (3) @(negedge clk);
    total++;
    if (dout[DW +: DW] !== 16'hA5C3) begin
      bad++; $display("FAIL hold: got %h want a5c3", dout[DW +: DW]);
    end
  endtask

  task automatic test_byte_merge();
    logic [DW-1:0] d;
    idle();
    drive(0, 8'd9, 16'h1111, 2'b10);
    drive(1, 8'd9, 16'h2222, 2'b01);
    @(negedge clk);
    idle();
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (collision !== 2'b00) begin bad++; $display("FAIL merge_coll: got %b want 00", collision); end
    read_word(0, 8'd9, d);
    total++;
    if (d !== 16'h2211) begin bad++; $display("FAIL merge_word: got %h want 2211", d); end
  endtask

  task automatic test_collision();
    logic [DW-1:0] d;
    idle();
    drive(0, 8'd3, 16'hAAAA, 2'b00);
    drive(1, 8'd3, 16'hBBBB, 2'b00);
    @(negedge clk);
    idle();
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (collision !== 2'b10) begin bad++; $display("FAIL coll_pulse: got %b want 10", collision); end
    @(negedge clk);
    total++;
    if (collision !== 2'b00) begin bad++; $display("FAIL coll_clear: got %b want 00", collision); end
    read_word(1, 8'd3, d);
    total++;
    if (d !== 16'hAAAA) begin bad++; $display("FAIL coll_word: got %h want aaaa", d); end
    drive(0, 8'd20, 16'h1234, 2'b10);
    drive(1, 8'd20, 16'hABCD, 2'b00);
    @(negedge clk);
    idle();
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (collision !== 2'b10) begin bad++; $display("FAIL part_coll: got %b want 10", collision); end
    read_word(0, 8'd20, d);
    total++;
    if (d !== 16'hAB34) begin bad++; $display("FAIL part_word: got %h want ab34", d); end
    drive(0, 8'd30, 16'h1357, 2'b00);
    drive(1, 8'd31, 16'h2468, 2'b00);
    @(negedge clk);
    idle();
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (collision !== 2'b00) begin bad++; $display("FAIL diff_coll: got %b want 00", collision); end
    read_word(1, 8'd30, d);
    total++;
    if (d !== 16'h1357) begin bad++; $display("FAIL diff_word30: got %h want 1357", d); end
    read_word(0, 8'd31, d);
    total++;
    if (d !== 16'h2468) begin bad++; $display("FAIL diff_word31: got %h want 2468", d); end
  endtask

  task automatic test_read_during_write();
    logic [DW-1:0] d;
    idle();
    drive(0, 8'd3, 16'h5555, 2'b00);
    drive(1, 8'd3, 16'h0000, 2'b11);
    @(negedge clk);
    idle();
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (dout[DW +: DW] !== 16'hAAAA) begin
      bad++; $display("FAIL rdw_other: got %h want aaaa", dout[DW +: DW]);
    end
    read_word(1, 8'd3, d);
    total++;
    if (d !== 16'h5555) begin bad++; $display("FAIL rdw_after: got %h want 5555", d); end
    drive(0, 8'd3, 16'h6666, 2'b00);
    @(negedge clk);
    idle();
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (dout[0 +: DW] !== 16'h5555) begin
      bad++; $display("FAIL rdw_self: got %h want 5555", dout[0 +: DW]);
    end
    read_word(0, 8'd3, d);
    total++;
    if (d !== 16'h6666) begin bad++; $display("FAIL rdw_self_after: got %h want 6666", d); end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] d;
    idle();
    drive(0, 8'd72, 16'h7777, 2'b00);
    @(negedge clk);
    read_word(0, 8'd72, d);
    total++;
    if (d !== 16'h7777) begin bad++; $display("FAIL oor_base: got %h want 7777", d); end
    read_word(0, 8'd200, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL oor_read: got %h want 0000", d); end
    drive(1, 8'd200, 16'h9999, 2'b00);
    @(negedge clk);
    read_word(1, 8'd72, d);
    total++;
    if (d !== 16'h7777) begin bad++; $display("FAIL oor_alias: got %h want 7777", d); end
    read_word(1, 8'd200, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL oor_drop: got %h want 0000", d); end
  endtask

  task automatic test_reset_mid_clear();
    logic [DW-1:0] d;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL midclear_ready: got %b want 0", ready); end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (dout !== '0) begin bad++; $display("FAIL midclear_dout: got %h want 0", dout); end
    rst_n = 1'b1;
    wait_ready("midclear_len");
    read_word(0, 8'd72, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL midclear_w72: got %h want 0000", d); end
    read_word(1, 8'd3, d);
    total++;
    if (d !== 16'h0000) begin bad++; $display("FAIL midclear_w3: got %h want 0000", d); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    test_reset();
    test_write_read();
    test_byte_merge();
    test_collision();
    test_read_during_write();
    test_out_of_range();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
